pe_tile_param: RTL and testbench

Parametrised processing-element tile for the island-style fabric. It generalises the fixed left-edge tile to any track count and track width, and connects tracks on all four sides. Memory-mapped configuration registers drive two connect boxes, a registered-capable CLB and a full four-sided switch box. The tile adds per-output pipeline registers and a one-cycle configuration readback port, and sits at every grid position, driven by the global configuration bus.

---
 rtl/pe_tile_pkg.sv | 33 +++
 rtl/pe_tile_sb_track.sv | 33 +++
 rtl/pe_tile_param.sv | 183 ++++++++++++++++++
 tb/tb_pe_tile_param.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_tile_pkg.sv
// Shared constants and types for the parametrised PE tile.
// Used by the tile top and its switch-box track slices.
package pe_tile_pkg;

  localparam logic [3:0] MOD_CLB     = 4'd0;
  localparam logic [3:0] MOD_CB0     = 4'd1;
  localparam logic [3:0] MOD_CB1     = 4'd2;
  localparam logic [3:0] MOD_SB_BASE = 4'd4;

  localparam int CLB_CFG_W = 4;
  localparam int CLB_OP_W  = 3;
  localparam int SB_CFG_W  = 3;
  localparam int SB_SRC_W  = 2;

  typedef enum logic [CLB_OP_W-1:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_ADD    = 3'd3,
    OP_SUB    = 3'd4,
    OP_PASS_A = 3'd5,
    OP_PASS_B = 3'd6,
    OP_NOT_A  = 3'd7
  } clb_op_e;

  typedef enum logic [1:0] {
    SIDE_N = 2'd0,
    SIDE_E = 2'd1,
    SIDE_S = 2'd2,
    SIDE_W = 2'd3
  } side_e;

endpackage

// File: rtl/pe_tile_sb_track.sv
// One switch-box output track: 4:1 source mux with an optional output flop.
// cand packs the three other-side tracks in [3*WIDTH-1:0] and pe_out on top.
module pe_tile_sb_track
  import pe_tile_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SB_SRC_W-1:0] src,
  input  logic                reg_en,
  input  logic [4*WIDTH-1:0]  cand,
  output logic [WIDTH-1:0]    out
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;

  always_comb begin
    out_d = cand[int'(src)*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = reg_en ? out_q : out_d;

endmodule

// File: rtl/pe_tile_param.sv
// Parametrised PE tile: two connect boxes, a CLB and a four-sided switch box,
// all configured through a memory-mapped register bus with one-cycle readback.
module pe_tile_param
  import pe_tile_pkg::*;
#(
  parameter int TRACKS    = 4,
  parameter int WIDTH     = 1,
  parameter int TILE_ID_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [TILE_ID_W-1:0]    tile_id,
  input  logic [31:0]             config_addr,
  input  logic [31:0]             config_data,
  input  logic                    config_we,
  input  logic                    config_re,
  output logic [31:0]             read_data,
  output logic                    read_valid,
  input  logic [TRACKS*WIDTH-1:0] in_0,
  input  logic [TRACKS*WIDTH-1:0] in_1,
  input  logic [TRACKS*WIDTH-1:0] in_2,
  input  logic [TRACKS*WIDTH-1:0] in_3,
  output logic [TRACKS*WIDTH-1:0] out_0,
  output logic [TRACKS*WIDTH-1:0] out_1,
  output logic [TRACKS*WIDTH-1:0] out_2,
  output logic [TRACKS*WIDTH-1:0] out_3,
  output logic [WIDTH-1:0]        pe_out
);

  localparam int BUS_W = TRACKS * WIDTH;
  localparam int SEL_W = $clog2(2 * TRACKS);

  logic [SEL_W-1:0]     cb0_sel_q, cb0_sel_d;
  logic [SEL_W-1:0]     cb1_sel_q, cb1_sel_d;
  logic [CLB_CFG_W-1:0] clb_cfg_q, clb_cfg_d;
  logic [SB_CFG_W-1:0]  sb_cfg_q [4][TRACKS];
  logic [SB_CFG_W-1:0]  sb_cfg_d [4][TRACKS];
  logic [31:0]          read_data_q, read_data_d;
  logic                 read_valid_q, read_valid_d;
  logic [WIDTH-1:0]     pe_q, pe_d;

  logic [4*BUS_W-1:0]   in_flat;
  logic [4*BUS_W-1:0]   out_flat;
  logic [WIDTH-1:0]     cb_a, cb_b;
  logic [31:0]          rd_val;

  logic        tile_hit;
  logic [3:0]  mod_id;
  logic [11:0] reg_idx;
  logic        idx_zero;
  logic        sb_mod;
  logic [1:0]  sb_side;
  clb_op_e     clb_op;
  logic        unused_cfg_bits;

  assign tile_hit = (config_addr[31:16] == 16'(tile_id));
  assign mod_id   = config_addr[15:12];
  assign reg_idx  = config_addr[11:0];
  assign idx_zero = (reg_idx == '0);
  assign sb_mod   = (mod_id[3:2] == MOD_SB_BASE[3:2]);
  assign sb_side  = mod_id[1:0];
  assign unused_cfg_bits = ^config_data[31:5];

  // Readback is taken from the current registers so a same-cycle write returns the old value.
  always_comb begin
    cb0_sel_d    = cb0_sel_q;
    cb1_sel_d    = cb1_sel_q;
    clb_cfg_d    = clb_cfg_q;
    sb_cfg_d     = sb_cfg_q;
    read_valid_d = 1'b0;
    read_data_d  = read_data_q;
    rd_val       = '0;

    if (idx_zero && mod_id == MOD_CLB) rd_val = 32'(clb_cfg_q);
    if (idx_zero && mod_id == MOD_CB0) rd_val = 32'(cb0_sel_q);
    if (idx_zero && mod_id == MOD_CB1) rd_val = 32'(cb1_sel_q);
    for (int s = 0; s < 4; s++) begin
      for (int t = 0; t < TRACKS; t++) begin
        if (sb_mod && int'(sb_side) == s && int'(reg_idx) == t) begin
          rd_val = 32'(sb_cfg_q[s][t]);
          if (tile_hit && config_we) sb_cfg_d[s][t] = config_data[SB_CFG_W-1:0];
        end
      end
    end

    if (tile_hit && config_we && idx_zero) begin
      if (mod_id == MOD_CLB) clb_cfg_d = config_data[CLB_CFG_W-1:0];
      if (mod_id == MOD_CB0) cb0_sel_d = config_data[SEL_W-1:0];
      if (mod_id == MOD_CB1) cb1_sel_d = config_data[SEL_W-1:0];
    end

    if (tile_hit && config_re) begin
      read_valid_d = 1'b1;
      read_data_d  = rd_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cb0_sel_q    <= '0;
      cb1_sel_q    <= '0;
      clb_cfg_q    <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      pe_q         <= '0;
      for (int s = 0; s < 4; s++) begin
        for (int t = 0; t < TRACKS; t++) begin
          sb_cfg_q[s][t] <= '0;
        end
      end
    end else begin
      cb0_sel_q    <= cb0_sel_d;
      cb1_sel_q    <= cb1_sel_d;
      clb_cfg_q    <= clb_cfg_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      pe_q         <= pe_d;
      sb_cfg_q     <= sb_cfg_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

  assign in_flat = {in_3, in_2, in_1, in_0};
  assign out_0   = out_flat[0*BUS_W +: BUS_W];
  assign out_1   = out_flat[1*BUS_W +: BUS_W];
  assign out_2   = out_flat[2*BUS_W +: BUS_W];
  assign out_3   = out_flat[3*BUS_W +: BUS_W];

  // CB0 sees side N, CB1 sees side E; the upper half of the select range taps our own outputs.
  always_comb begin
    cb_a = '0;
    cb_b = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (int'(cb0_sel_q) == t)          cb_a = in_flat[0*BUS_W + t*WIDTH +: WIDTH];
      if (int'(cb0_sel_q) == TRACKS + t) cb_a = out_flat[0*BUS_W + t*WIDTH +: WIDTH];
      if (int'(cb1_sel_q) == t)          cb_b = in_flat[1*BUS_W + t*WIDTH +: WIDTH];
      if (int'(cb1_sel_q) == TRACKS + t) cb_b = out_flat[1*BUS_W + t*WIDTH +: WIDTH];
    end
  end

  assign clb_op = clb_op_e'(clb_cfg_q[CLB_OP_W-1:0]);

  always_comb begin
    case (clb_op)
      OP_AND:    pe_d = cb_a & cb_b;
      OP_OR:     pe_d = cb_a | cb_b;
      OP_XOR:    pe_d = cb_a ^ cb_b;
      OP_ADD:    pe_d = cb_a + cb_b;
      OP_SUB:    pe_d = cb_a - cb_b;
      OP_PASS_A: pe_d = cb_a;
      OP_PASS_B: pe_d = cb_b;
      OP_NOT_A:  pe_d = ~cb_a;
      default:   pe_d = '0;
    endcase
  end

  assign pe_out = clb_cfg_q[CLB_CFG_W-1] ? pe_q : pe_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_side
    // Other sides in ascending order select sources 0..2.
    localparam int OTH0 = (0 < gi) ? 0 : 1;
    localparam int OTH1 = (1 < gi) ? 1 : 2;
    localparam int OTH2 = (2 < gi) ? 2 : 3;
    for (genvar gt = 0; gt < TRACKS; gt++) begin : g_track
      logic [4*WIDTH-1:0] cand;
      assign cand = {pe_out,
                     in_flat[OTH2*BUS_W + gt*WIDTH +: WIDTH],
                     in_flat[OTH1*BUS_W + gt*WIDTH +: WIDTH],
                     in_flat[OTH0*BUS_W + gt*WIDTH +: WIDTH]};
      pe_tile_sb_track #(.WIDTH(WIDTH)) u_track (
        .clk    (clk),
        .rst_n  (reset),
        .src    (sb_cfg_q[gi][gt][SB_SRC_W-1:0]),
        .reg_en (sb_cfg_q[gi][gt][SB_CFG_W-1]),
        .cand   (cand),
        .out    (out_flat[gi*BUS_W + gt*WIDTH +: WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_pe_tile_param.sv
// Bench for pe_tile_param (TRACKS=4, WIDTH=8): directed literal checks plus
// randomized traffic compared every cycle against a behavioural tile model.
module tb_pe_tile_param;

  localparam int TR = 4;
  localparam int W  = 8;
  localparam logic [15:0] TILE  = 16'h0012;
  localparam logic [15:0] OTHER = 16'h0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] tile_id = TILE;
  logic [31:0] config_addr = '0;
  logic [31:0] config_data = '0;
  logic        config_we = 1'b0;
  logic        config_re = 1'b0;
  logic [31:0] read_data;
  logic        read_valid;
  logic [31:0] in_0 = '0, in_1 = '0, in_2 = '0, in_3 = '0;
  logic [31:0] out_0, out_1, out_2, out_3;
  logic [7:0]  pe_out;

  pe_tile_param #(.TRACKS(TR), .WIDTH(W), .TILE_ID_W(16)) dut (
    .clk(clk), .reset(reset), .tile_id(tile_id),
    .config_addr(config_addr), .config_data(config_data),
    .config_we(config_we), .config_re(config_re),
    .read_data(read_data), .read_valid(read_valid),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .pe_out(pe_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cb0 = 0, m_cb1 = 0, m_clb = 0;
  int          m_sb [4][4];
  logic [7:0]  m_pe_q = '0;
  logic [7:0]  m_sb_q [4][4];
  logic [31:0] m_rd_data = '0;
  logic        m_rd_valid = 1'b0;
  logic [7:0]  c_pe = '0;
  logic [7:0]  c_sb [4][4];

  function automatic logic [31:0] model_reg(input logic [31:0] a);
    int mod = int'(a[15:12]);
    int idx = int'(a[11:0]);
    if (a[31:16] != TILE) return 32'h0;
    if (idx == 0 && mod == 0) return 32'(m_clb);
    if (idx == 0 && mod == 1) return 32'(m_cb0);
    if (idx == 0 && mod == 2) return 32'(m_cb1);
    if (mod >= 4 && mod <= 7 && idx < TR) return 32'(m_sb[mod-4][idx]);
    return 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    int mod = int'(a[15:12]);
    int idx = int'(a[11:0]);
    if (a[31:16] == TILE) begin
      if (idx == 0 && mod == 0) m_clb <= int'(d[3:0]);
      if (idx == 0 && mod == 1) m_cb0 <= int'(d[2:0]);
      if (idx == 0 && mod == 2) m_cb1 <= int'(d[2:0]);
      if (mod >= 4 && mod <= 7 && idx < TR) m_sb[mod-4][idx] <= int'(d[2:0]);
    end
  endtask

  function automatic logic [7:0] cb_pick(input int sel, input logic [31:0] inb, input logic [31:0] outb);
    if (sel < TR) return inb[sel*8 +: 8];
    if (sel < 2*TR) return outb[(sel-TR)*8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] alu(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return a + b;
      4: return a - b;
      5: return a;
      6: return b;
      default: return ~a;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cb0 <= 0; m_cb1 <= 0; m_clb <= 0;
      m_pe_q <= '0; m_rd_data <= '0; m_rd_valid <= 1'b0;
      for (int s = 0; s < 4; s++)
        for (int t = 0; t < TR; t++) begin
          m_sb[s][t] <= 0;
          m_sb_q[s][t] <= '0;
        end
    end else begin
      m_pe_q <= c_pe;
      for (int s = 0; s < 4; s++)
        for (int t = 0; t < TR; t++) m_sb_q[s][t] <= c_sb[s][t];
      if (config_re && config_addr[31:16] == TILE) begin
        m_rd_valid <= 1'b1;
        m_rd_data  <= model_reg(config_addr);
      end else begin
        m_rd_valid <= 1'b0;
      end
      if (config_we) model_write(config_addr, config_data);
    end
  end

  // Settle the tile by repeated evaluation; legal configs converge within two passes.
  always @(negedge clk) begin : cmp
    logic [31:0] ins [4];
    logic [7:0]  outs [4][4];
    logic [7:0]  nxt [4][4];
    logic [31:0] packed_out [4];
    logic [7:0]  pe_v, a, b, alu_v;
    int oth [3];
    int k, src;
    ins[0] = in_0; ins[1] = in_1; ins[2] = in_2; ins[3] = in_3;
    pe_v  = (m_clb & 8) != 0 ? m_pe_q : 8'h00;
    alu_v = 8'h00;
    for (int it = 0; it < 3; it++) begin
      for (int s = 0; s < 4; s++) begin
        k = 0;
        for (int o = 0; o < 4; o++) if (o != s) begin oth[k] = o; k++; end
        for (int t = 0; t < TR; t++) begin
          src = m_sb[s][t] & 3;
          nxt[s][t]  = (src < 3) ? ins[oth[src]][t*8 +: 8] : pe_v;
          outs[s][t] = (m_sb[s][t] & 4) != 0 ? m_sb_q[s][t] : nxt[s][t];
        end
        packed_out[s] = {outs[s][3], outs[s][2], outs[s][1], outs[s][0]};
      end
      a     = cb_pick(m_cb0, ins[0], packed_out[0]);
      b     = cb_pick(m_cb1, ins[1], packed_out[1]);
      alu_v = alu(m_clb & 7, a, b);
      pe_v  = (m_clb & 8) != 0 ? m_pe_q : alu_v;
    end
    c_pe <= alu_v;
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < TR; t++) c_sb[s][t] <= nxt[s][t];
    check("model_pe_out", 32'(pe_out), 32'(pe_v));
    check("model_out_0", out_0, packed_out[0]);
    check("model_out_1", out_1, packed_out[1]);
    check("model_out_2", out_2, packed_out[2]);
    check("model_out_3", out_3, packed_out[3]);
    check("model_read_valid", 32'(read_valid), 32'(m_rd_valid));
    check("model_read_data", read_data, m_rd_data);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] addr_of(input logic [15:0] tid, input int mod, input int idx);
    return {tid, 4'(mod), 12'(idx)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [15:0] tid, input int mod, input int idx, input logic [31:0] d);
    config_addr = addr_of(tid, mod, idx);
    config_data = d;
    config_we   = 1'b1;
    cycle();
    config_we   = 1'b0;
  endtask

  task automatic cfg_read(input string name, input int mod, input int idx, input logic [31:0] exp);
    config_addr = addr_of(TILE, mod, idx);
    config_re   = 1'b1;
    cycle();
    config_re   = 1'b0;
    check({name, "_valid"}, 32'(read_valid), 32'h1);
    check({name, "_data"}, read_data, exp);
    $display("read mod %0d idx %0d -> valid %0b data 0x%08h", mod, idx, read_valid, read_data);
  endtask

  // A combinational loop exists only through a CB tapping an output track that is pe_out unregistered.
  function automatic bit loop_free(input int c0, input int c1, input int cl, input int sbc [4][4]);
    if ((cl & 8) != 0) return 1'b1;
    if (c0 >= TR && c0 < 2*TR && (sbc[0][c0-TR] & 7) == 3) return 1'b0;
    if (c1 >= TR && c1 < 2*TR && (sbc[1][c1-TR] & 7) == 3) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    // Reset with every input high: everything is fed combinationally by the cleared config.
    in_0 = '1; in_1 = '1; in_2 = '1; in_3 = '1;
    reset = 1'b0;
    repeat (3) cycle();
    check("rst_read_valid", 32'(read_valid), 32'h0);
    check("rst_pe_out", 32'(pe_out), 32'h0000_00FF);
    check("rst_out_0", out_0, 32'hFFFF_FFFF);
    check("rst_out_2", out_2, 32'hFFFF_FFFF);
    reset = 1'b1;
    cycle();
    cfg_read("rst_cb0", 1, 0, 32'h0);

    // ADD through a registered CLB routed to out_2 track 0.
    in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;
    cfg_write(TILE, 1, 0, 32'h1);
    cfg_write(TILE, 2, 0, 32'h6);
    cfg_write(TILE, 0, 0, 32'hB);
    cfg_write(TILE, 6, 0, 32'h3);
    in_0 = 32'h0020_F000;
    check("add_before_edge", 32'(out_2[7:0]), 32'h00);
    cycle();
    check("add_reg_out2", 32'(out_2[7:0]), 32'h10);
    $display("add: out_2[7:0] = 0x%02h", out_2[7:0]);

    // SB side N track 3 from W, combinational.
    cfg_write(TILE, 4, 3, 32'h2);
    in_3 = 32'hA500_0000;
    #1;
    check("sb_comb_out0_t3", 32'(out_0[31:24]), 32'hA5);
    $display("sb comb: out_0[31:24] = 0x%02h", out_0[31:24]);
    cycle();

    // Readback, single-cycle pulse, unmapped module, back-to-back reads.
    cfg_write(TILE, 2, 0, 32'h5);
    cfg_read("rb_cb1", 2, 0, 32'h5);
    cycle();
    check("rb_pulse_low", 32'(read_valid), 32'h0);
    cfg_read("rb_unmapped", 3, 0, 32'h0);
    config_addr = addr_of(TILE, 2, 0);
    config_re = 1'b1;
    cycle();
    check("b2b_first_valid", 32'(read_valid), 32'h1);
    check("b2b_first_data", read_data, 32'h5);
    config_addr = addr_of(TILE, 0, 0);
    cycle();
    config_re = 1'b0;
    check("b2b_second_valid", 32'(read_valid), 32'h1);
    check("b2b_second_data", read_data, 32'hB);

    // Foreign-tile write leaves the register alone.
    cfg_write(OTHER, 2, 0, 32'h7);
    cfg_read("foreign_wr", 2, 0, 32'h5);

    // Simultaneous write and read returns the pre-write value.
    cfg_write(TILE, 0, 0, 32'h8);
    config_addr = addr_of(TILE, 0, 0);
    config_data = 32'h2;
    config_we = 1'b1; config_re = 1'b1;
    cycle();
    config_we = 1'b0; config_re = 1'b0;
    check("wr_rd_old", read_data, 32'h8);
    cfg_read("wr_rd_new", 0, 0, 32'h2);
    cfg_write(TILE, 0, 0, 32'h8);
    config_data = 32'h2;
    config_we = 1'b1; config_re = 1'b1;
    cycle();
    config_we = 1'b0; config_re = 1'b0;
    check("wr_rd_old2", read_data, 32'h8);
    reset = 1'b0;
    cycle();
    check("rst_mid_valid", 32'(read_valid), 32'h0);
    check("rst_mid_data", read_data, 32'h0);
    reset = 1'b1;
    cfg_read("after_rst_clb", 0, 0, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int c0, c1, cl, mod, idx;
      int sbc [4][4];
      logic [15:0] tid;
      logic [31:0] d;
      in_0 = $urandom; in_1 = $urandom; in_2 = $urandom; in_3 = $urandom;
      config_we = 1'b0;
      config_re = 1'b0;
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tid = ($urandom_range(0, 7) == 0) ? OTHER : TILE;
      mod = $urandom_range(0, 7);
      idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : ((mod >= 4) ? $urandom_range(0, TR-1) : 0);
      d = $urandom;
      config_addr = addr_of(tid, mod, idx);
      config_data = d;
      c0 = m_cb0; c1 = m_cb1; cl = m_clb;
      for (int s = 0; s < 4; s++)
        for (int t = 0; t < TR; t++) sbc[s][t] = m_sb[s][t];
      if (tid == TILE) begin
        if (idx == 0 && mod == 0) cl = int'(d[3:0]);
        if (idx == 0 && mod == 1) c0 = int'(d[2:0]);
        if (idx == 0 && mod == 2) c1 = int'(d[2:0]);
        if (mod >= 4 && idx < TR) sbc[mod-4][idx] = int'(d[2:0]);
      end
      if ($urandom_range(0, 2) == 0 && loop_free(c0, c1, cl, sbc)) config_we = 1'b1;
      if ($urandom_range(0, 2) == 0) config_re = 1'b1;
      cycle();
      if (n % 250 == 0)
        $display("rand %0d: we %0b re %0b addr 0x%08h pe_out 0x%02h rv %0b rd 0x%08h",
                 n, config_we, config_re, config_addr, pe_out, read_valid, read_data);
    end
    config_we = 1'b0;
    config_re = 1'b0;
    reset = 1'b1;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
